// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: mode encoding, FSM states
// and the burst-mode qualifier used by the top level.
package usr_pkg;

  typedef enum logic [2:0] {
    HOLD = 3'd0,
    SHR  = 3'd1,
    SHL  = 3'd2,
    LOAD = 3'd3,
    ROR  = 3'd4,
    ROL  = 3'd5,
    ASR  = 3'd6,
    RSVD = 3'd7
  } usr_mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } usr_state_e;

  // Only single-bit step modes can be repeated as a counted burst.
  function automatic logic is_burst_mode(usr_mode_e mode);
    return (mode inside {SHR, SHL, ROR, ROL, ASR});
  endfunction

endpackage

// File: rtl/usr_shift_step.sv
// Combinational next-value function for one register update; shared by the
// direct path and the burst path so both apply identical step semantics.
module usr_shift_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q_i,
  input  usr_mode_e        mode_i,
  input  logic             sl_i,
  input  logic             sr_i,
  input  logic [WIDTH-1:0] par_i,
  output logic [WIDTH-1:0] q_o
);

  always_comb begin
    q_o = q_i;
    case (mode_i)
      SHR:     q_o = {sl_i, q_i[WIDTH-1:1]};
      SHL:     q_o = {q_i[WIDTH-2:0], sr_i};
      LOAD:    q_o = par_i;
      ROR:     q_o = {q_i[0], q_i[WIDTH-1:1]};
      ROL:     q_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
      ASR:     q_o = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
      default: q_o = q_i;
    endcase
  end

endmodule

// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal shift register with a direct mode (one step per edge)
// and a counted burst mode. All state updates on the falling clock edge.
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       m,
  input  logic             sl,
  input  logic             sr,
  input  logic [WIDTH-1:0] par_in,
  input  logic             start,
  input  logic [CNT_W-1:0] amount,
  output logic [WIDTH-1:0] par_out,
  output logic             ser_out_l,
  output logic             ser_out_r,
  output logic             busy,
  output logic             done,
  output usr_state_e       dbg_state_o
);

  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);

  // Handshake: start is sampled only while busy=0; a burst-mode start makes
  // busy rise after that edge, and done pulses for the one cycle after the
  // edge that completes the burst (the same edge that drops busy).
  usr_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  usr_mode_e        bmode_q, bmode_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             done_q, done_d;
  usr_mode_e        step_mode;
  logic [WIDTH-1:0] step_q;

  usr_shift_step #(.WIDTH(WIDTH)) u_step (
    .q_i    (q_q),
    .mode_i (step_mode),
    .sl_i   (sl),
    .sr_i   (sr),
    .par_i  (par_in),
    .q_o    (step_q)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bmode_d   = bmode_q;
    q_d       = q_q;
    done_d    = 1'b0;
    step_mode = usr_mode_e'(m);
    case (state_q)
      IDLE: begin
        if (start && is_burst_mode(usr_mode_e'(m))) begin
          bmode_d = usr_mode_e'(m);
          cnt_d   = (amount > WIDTH_C) ? WIDTH_C : amount;
          state_d = RUN;
        end else begin
          q_d = step_q;
        end
      end
      RUN: begin
        step_mode = bmode_q;
        if (cnt_q == '0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          q_d   = step_q;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bmode_q <= HOLD;
      q_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bmode_q <= bmode_d;
      q_q     <= q_d;
      done_q  <= done_d;
    end
  end

  assign par_out     = q_q;
  assign ser_out_l   = q_q[WIDTH-1];
  assign ser_out_r   = q_q[0];
  assign busy        = (state_q == RUN);
  assign done        = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Bench for universal_shift_reg (WIDTH=8): directed scenarios plus random
// traffic, each edge predicted by a reference model and compared.
module tb_universal_shift_reg;
  import usr_pkg::*;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [2:0]    m = '0;
  logic          sl = 1'b0;
  logic          sr = 1'b0;
  logic [W-1:0]  par_in = '0;
  logic          start = 1'b0;
  logic [CW-1:0] amount = '0;
  logic [W-1:0]  par_out;
  logic          ser_out_l, ser_out_r, busy, done;
  usr_state_e    dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W+1:0] exp_q[$];

  // reference model state
  logic [W-1:0] mdl_q;
  logic         mdl_busy, mdl_done;
  int           mdl_cnt;
  logic [2:0]   mdl_mode;

  universal_shift_reg #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m           (m),
    .sl          (sl),
    .sr          (sr),
    .par_in      (par_in),
    .start       (start),
    .amount      (amount),
    .par_out     (par_out),
    .ser_out_l   (ser_out_l),
    .ser_out_r   (ser_out_r),
    .busy        (busy),
    .done        (done),
    .dbg_state_o (dbg_state)
  );

  // clock / reset: active edge is negedge, outputs sampled at posedge
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_step(input logic [W-1:0] q, input logic [2:0] md,
                                            input logic s_l, input logic s_r,
                                            input logic [W-1:0] pin);
    case (md)
      3'd1:    return {s_l, q[W-1:1]};
      3'd2:    return {q[W-2:0], s_r};
      3'd3:    return pin;
      3'd4:    return {q[0], q[W-1:1]};
      3'd5:    return {q[W-2:0], q[W-1]};
      3'd6:    return {q[W-1], q[W-1:1]};
      default: return q;
    endcase
  endfunction

  task automatic model_reset();
    mdl_q    = '0;
    mdl_busy = 1'b0;
    mdl_done = 1'b0;
    mdl_cnt  = 0;
    mdl_mode = 3'd0;
  endtask

  task automatic model_edge();
    mdl_done = 1'b0;
    if (!mdl_busy) begin
      if (start && (m inside {3'd1, 3'd2, 3'd4, 3'd5, 3'd6})) begin
        mdl_mode = m;
        mdl_cnt  = (int'(amount) > W) ? W : int'(amount);
        mdl_busy = 1'b1;
      end else begin
        mdl_q = ref_step(mdl_q, m, sl, sr, par_in);
      end
    end else if (mdl_cnt == 0) begin
      mdl_busy = 1'b0;
      mdl_done = 1'b1;
    end else begin
      mdl_q = ref_step(mdl_q, mdl_mode, sl, sr, par_in);
      mdl_cnt--;
      if (mdl_cnt == 0) begin
        mdl_busy = 1'b0;
        mdl_done = 1'b1;
      end
    end
  endtask

  // driver: set inputs (called at posedge time, away from the active edge)
  task automatic drv(input logic [2:0] md, input logic s_l, input logic s_r,
                     input logic [W-1:0] pin, input logic st, input logic [CW-1:0] amt);
    m      = md;
    sl     = s_l;
    sr     = s_r;
    par_in = pin;
    start  = st;
    amount = amt;
  endtask

  // one active edge: predict, let the DUT clock, compare at the next posedge
  task automatic tick();
    logic [W+1:0] exp;
    model_edge();
    exp_q.push_back({mdl_q, mdl_busy, mdl_done});
    @(negedge clk);
    @(posedge clk);
    exp = exp_q.pop_front();
    check("q_busy_done", {22'd0, par_out, busy, done}, {22'd0, exp});
    check("ser_out", {30'd0, ser_out_l, ser_out_r}, {30'd0, exp[W+1], exp[2]});
    check("state", {31'd0, dbg_state == RUN}, {31'd0, exp[1]});
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    check("reset_q", {24'd0, par_out}, 32'h00);
    check("reset_busy_done", {30'd0, busy, done}, 32'd0);
    rst_n = 1'b1;

    // direct modes
    drv(3'd3, 0, 0, 8'hA5, 0, 0); tick(); check("load_a5", {24'd0, par_out}, 32'hA5);
    drv(3'd1, 0, 0, 8'h00, 0, 0); tick(); check("shr_52",  {24'd0, par_out}, 32'h52);
    drv(3'd2, 0, 1, 8'h00, 0, 0); tick(); check("shl_a5",  {24'd0, par_out}, 32'hA5);
    drv(3'd3, 0, 0, 8'h96, 0, 0); tick();
    drv(3'd6, 0, 0, 8'h00, 0, 0); tick(); check("asr_cb",  {24'd0, par_out}, 32'hCB);
    drv(3'd7, 1, 1, 8'hFF, 0, 0); tick(); check("rsvd_cb", {24'd0, par_out}, 32'hCB);

    // burst rotate left by 3
    drv(3'd3, 0, 0, 8'h81, 0, 0); tick();
    drv(3'd5, 0, 0, 8'h00, 1, 3); tick();
    check("rol_start", {23'd0, par_out, busy}, {23'd0, 8'h81, 1'b1});
    drv(3'd0, 0, 0, 8'h00, 0, 0); tick(); check("rol_1", {24'd0, par_out}, 32'h03);
    tick(); check("rol_2", {24'd0, par_out}, 32'h06);
    tick(); check("rol_3", {22'd0, par_out, busy, done}, {22'd0, 8'h0C, 1'b0, 1'b1});
    tick(); check("rol_done_clear", {31'd0, done}, 32'd0);

    // clamp: amount 12 on an 8-bit register rotates a full turn
    drv(3'd3, 0, 0, 8'h3C, 0, 0); tick();
    drv(3'd4, 0, 0, 8'h00, 1, 12); tick();
    drv(3'd0, 0, 0, 8'h00, 0, 0);
    repeat (7) tick();
    check("clamp_not_done", {30'd0, busy, done}, {30'd0, 1'b1, 1'b0});
    tick();
    check("clamp_end", {22'd0, par_out, busy, done}, {22'd0, 8'h3C, 1'b0, 1'b1});

    // zero amount
    drv(3'd5, 0, 0, 8'h00, 1, 0); tick();
    drv(3'd0, 0, 0, 8'h00, 0, 0); tick();
    check("zero_amt", {22'd0, par_out, busy, done}, {22'd0, 8'h3C, 1'b0, 1'b1});

    // ignored inputs during RUN, live sl, start held through done edge
    drv(3'd3, 0, 0, 8'h00, 0, 0); tick();
    drv(3'd1, 0, 0, 8'h00, 1, 3); tick();
    drv(3'd3, 1, 0, 8'hFF, 1, 7); tick(); check("sl_1", {24'd0, par_out}, 32'h80);
    drv(3'd3, 0, 0, 8'hFF, 1, 7); tick(); check("sl_2", {24'd0, par_out}, 32'h40);
    drv(3'd5, 1, 0, 8'hFF, 1, 2); tick();
    check("sl_3_done", {22'd0, par_out, busy, done}, {22'd0, 8'hA0, 1'b0, 1'b1});
    tick();
    check("restart", {22'd0, par_out, busy, done}, {22'd0, 8'hA0, 1'b1, 1'b0});
    drv(3'd0, 0, 0, 8'h00, 0, 0); tick(); tick();
    check("restart_end", {22'd0, par_out, busy, done}, {22'd0, 8'h82, 1'b0, 1'b1});

    // non-burst start
    drv(3'd3, 0, 0, 8'h5A, 1, 4); tick();
    check("start_load", {22'd0, par_out, busy, done}, {22'd0, 8'h5A, 1'b0, 1'b0});
    drv(3'd0, 0, 0, 8'h00, 0, 0); tick();

    // random traffic
    for (int i = 0; i < 300; i++) begin
      drv(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0),
          CW'($urandom_range(0, 15)));
      tick();
    end

    // async reset in the middle of a burst
    drv(3'd3, 0, 0, 8'hC3, 0, 0); tick();
    drv(3'd4, 0, 0, 8'h00, 1, 6); tick();
    drv(3'd0, 0, 0, 8'h00, 0, 0); tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_q", {24'd0, par_out}, 32'h00);
    check("arst_busy_done", {30'd0, busy, done}, 32'd0);
    @(posedge clk);
    rst_n = 1'b1;
    drv(3'd3, 0, 0, 8'h77, 0, 0); tick(); check("post_reset_load", {24'd0, par_out}, 32'h77);
    drv(3'd2, 0, 0, 8'h00, 0, 0); tick(); check("post_reset_shl", {24'd0, par_out}, 32'hEE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
